// File: rtl/sequenciador_medidas_if.sv
// Bus between the measurement sequencer, the top-level control logic and the
// HC-SR04 interface.
// The slave side is the sequencer. The master side is whoever drives the enable
// and the sensor responses.
interface sequenciador_medidas_if;
    logic        ligar;
    logic        pronto_medida;
    logic [11:0] medida_in;
    logic        medir;
    logic [11:0] media;
    logic        media_valida;
    logic        erro;
    logic [3:0]  db_estado;

    modport master (
        output ligar, pronto_medida, medida_in,
        input  medir, media, media_valida, erro, db_estado
    );

    modport slave (
        input  ligar, pronto_medida, medida_in,
        output medir, media, media_valida, erro, db_estado
    );
endinterface

// File: rtl/sequenciador_medidas.sv
// Periodic measurement sequencer for the ultrasonic sensor.
// It fires medir, waits for pronto under a timeout, and averages 2^AMOSTRAS_LOG2
// valid samples. It then publishes the truncated mean with a one-cycle strobe.
module sequenciador_medidas #(
    parameter int PERIODO       = 2500000,
    parameter int TIMEOUT       = 1500000,
    parameter int AMOSTRAS_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    sequenciador_medidas_if.slave bus
);

    localparam int ACC_W    = 12 + AMOSTRAS_LOG2;
    localparam int CONT_W   = AMOSTRAS_LOG2 + 1;
    localparam int MAIOR    = (PERIODO > TIMEOUT) ? PERIODO : TIMEOUT;
    localparam int CICLOS_W = $clog2(MAIOR + 1);

    localparam logic [CONT_W-1:0]   ULTIMA      = CONT_W'((1 << AMOSTRAS_LOG2) - 1);
    localparam logic [CICLOS_W-1:0] FIM_TIMEOUT = CICLOS_W'(TIMEOUT - 1);
    localparam logic [CICLOS_W-1:0] FIM_PERIODO = CICLOS_W'(PERIODO - 1);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        DISPARA = 3'd1,
        AGUARDA = 3'd2,
        PUBLICA = 3'd3,
        FALHA   = 3'd4,
        ESPERA  = 3'd5
    } estado_t;

    estado_t             estado;
    estado_t             prox_estado;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    soma;
    logic [CONT_W-1:0]   cont;
    logic [CICLOS_W-1:0] ciclos;
    logic [11:0]         media_reg;

    // The sum of 2^AMOSTRAS_LOG2 twelve-bit samples always fits in ACC_W bits.
    assign soma = acc + ACC_W'(bus.medida_in);

    // State register. Reset drops straight to INICIAL, even mid-measurement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic. Losing ligar overrides every other transition.
    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL: if (bus.ligar) prox_estado = DISPARA;
            DISPARA: prox_estado = AGUARDA;
            AGUARDA: begin
                if (bus.pronto_medida) begin
                    prox_estado = (cont == ULTIMA) ? PUBLICA : ESPERA;
                end else if (ciclos == FIM_TIMEOUT) begin
                    prox_estado = FALHA;
                end
            end
            PUBLICA: prox_estado = ESPERA;
            FALHA:   prox_estado = ESPERA;
            ESPERA:  if (ciclos == FIM_PERIODO) prox_estado = DISPARA;
            default: prox_estado = INICIAL;
        endcase
        if (!bus.ligar) begin
            prox_estado = INICIAL;
        end
    end

    // Datapath: cycle counter, sample accumulator and the published mean.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ciclos    <= '0;
            acc       <= '0;
            cont      <= '0;
            media_reg <= '0;
        end else begin
            if (estado == INICIAL || prox_estado != estado) begin
                ciclos <= '0;
            end else begin
                ciclos <= ciclos + 1'b1;
            end

            case (estado)
                INICIAL, PUBLICA: begin
                    acc  <= '0;
                    cont <= '0;
                end
                AGUARDA: begin
                    if (bus.pronto_medida && bus.ligar) begin
                        acc  <= soma;
                        cont <= cont + 1'b1;
                    end
                end
                default: ;
            endcase

            if (estado == AGUARDA && prox_estado == PUBLICA) begin
                media_reg <= soma[ACC_W-1 -: 12];
            end
        end
    end

    assign bus.medir        = (estado == DISPARA);
    assign bus.media_valida = (estado == PUBLICA);
    assign bus.erro         = (estado == FALHA);
    assign bus.db_estado    = {1'b0, estado};
    assign bus.media        = media_reg;

endmodule

// File: tb/tb_sequenciador_medidas.sv
// Self-checking bench for sequenciador_medidas.
// A high-level model predicts means, strobe cycles and medir spacing.
// It works from a sample queue and plain cycle arithmetic.
module tb_sequenciador_medidas;

    localparam int PERIODO       = 10;
    localparam int TIMEOUT       = 20;
    localparam int AMOSTRAS_LOG2 = 2;
    localparam int N_AMOSTRAS    = 1 << AMOSTRAS_LOG2;
    localparam int LIMITE_ESPERA = 4 * (PERIODO + TIMEOUT);

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    int amostras[$];
    int ultima_media = 0;

    int obs_erro_ciclo;
    int obs_valida_ciclo;
    int obs_media;
    int obs_gap;
    int obs_n_erro;
    int obs_n_valida;

    sequenciador_medidas_if bus();

    sequenciador_medidas #(
        .PERIODO(PERIODO),
        .TIMEOUT(TIMEOUT),
        .AMOSTRAS_LOG2(AMOSTRAS_LOG2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Record the first cycle (counted from medir) of each strobe, plus pulse counts.
    task automatic observa(input int idx);
        if (bus.erro === 1'b1) begin
            obs_n_erro++;
            if (obs_erro_ciclo == 0) obs_erro_ciclo = idx;
        end
        if (bus.media_valida === 1'b1) begin
            obs_n_valida++;
            if (obs_valida_ciclo == 0) begin
                obs_valida_ciclo = idx;
                obs_media = int'(bus.media);
            end
        end
    endtask

    // Stimulus only. It starts in a medir cycle and optionally answers after 'atraso' cycles.
    // It then runs to the next medir and leaves the observations in obs_*.
    task automatic executa_medida(input bit responde, input int atraso, input int valor);
        int  idx;
        bit  achou;
        obs_erro_ciclo   = 0;
        obs_valida_ciclo = 0;
        obs_media        = -1;
        obs_gap          = -1;
        obs_n_erro       = 0;
        obs_n_valida     = 0;
        idx              = 0;
        if (responde) begin
            for (int i = 0; i < atraso; i++) begin
                tick();
                idx++;
                observa(idx);
            end
            bus.pronto_medida = 1'b1;
            bus.medida_in     = 12'(valor);
            tick();
            idx++;
            bus.pronto_medida = 1'b0;
            bus.medida_in     = 12'($urandom);
            observa(idx);
        end
        achou = 1'b0;
        for (int i = 0; i < LIMITE_ESPERA && !achou; i++) begin
            tick();
            idx++;
            observa(idx);
            if (bus.medir === 1'b1) begin
                obs_gap = idx;
                achou   = 1'b1;
            end
        end
    endtask

    // Reference model: collect samples and return the mean once a full set is in, else -1.
    function automatic int modelo_amostra(input int valor);
        int soma;
        amostras.push_back(valor);
        if (amostras.size() < N_AMOSTRAS) return -1;
        soma = 0;
        foreach (amostras[i]) soma += amostras[i];
        amostras.delete();
        ultima_media = soma / N_AMOSTRAS;
        return ultima_media;
    endfunction

    task automatic test_reset();
        bus.ligar         = 1'b1;
        bus.pronto_medida = 1'b0;
        bus.medida_in     = 12'd0;
        reset             = 1'b0;
        repeat (3) tick();
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("[TB] FAIL reset_db_estado: got %0d expected 0", bus.db_estado); end
        checks++; if (bus.medir !== 1'b0) begin errors++; $display("[TB] FAIL reset_medir: got %b expected 0", bus.medir); end
        checks++; if (bus.media !== 12'd0) begin errors++; $display("[TB] FAIL reset_media: got %0d expected 0", bus.media); end
        checks++; if (bus.media_valida !== 1'b0) begin errors++; $display("[TB] FAIL reset_valida: got %b expected 0", bus.media_valida); end
        checks++; if (bus.erro !== 1'b0) begin errors++; $display("[TB] FAIL reset_erro: got %b expected 0", bus.erro); end
        reset = 1'b1;
        tick();
        checks++; if (bus.medir !== 1'b1) begin errors++; $display("[TB] FAIL first_medir: got %b expected 1", bus.medir); end
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("[TB] FAIL first_db_estado: got %0d expected 1", bus.db_estado); end
    endtask

    // Answered measurements from a small table of values at a fixed delay.
    task automatic test_media_basica(input int base, input int passo, input int atraso, input int media_alvo);
        int valor, esp, gap_esp;
        for (int n = 0; n < N_AMOSTRAS; n++) begin
            valor = base + n * passo;
            executa_medida(1'b1, atraso, valor);
            esp     = modelo_amostra(valor);
            gap_esp = atraso + 1 + PERIODO + ((esp >= 0) ? 1 : 0);
            checks++; if (obs_n_erro != 0) begin errors++; $display("[TB] FAIL basic_erro[%0d]: got %0d pulses expected 0", n, obs_n_erro); end
            checks++; if (obs_valida_ciclo != ((esp >= 0) ? atraso + 1 : 0) || obs_n_valida != ((esp >= 0) ? 1 : 0)) begin errors++; $display("[TB] FAIL basic_valida[%0d]: got cycle %0d/%0d pulses expected cycle %0d", n, obs_valida_ciclo, obs_n_valida, (esp >= 0) ? atraso + 1 : 0); end
            if (esp >= 0) begin
                checks++; if (obs_media != esp) begin errors++; $display("[TB] FAIL basic_media[%0d]: got %0d expected %0d", n, obs_media, esp); end
            end
            checks++; if (obs_gap != gap_esp) begin errors++; $display("[TB] FAIL basic_gap[%0d]: got %0d expected %0d", n, obs_gap, gap_esp); end
        end
        checks++; if (bus.media !== 12'(media_alvo)) begin errors++; $display("[TB] FAIL basic_media_hold: got %0d expected %0d", bus.media, media_alvo); end
    endtask

    // Lost measurement, then a full set of 50s that must not include the lost sample.
    task automatic test_timeout();
        int atraso, esp, gap_esp;
        executa_medida(1'b0, 0, 0);
        checks++; if (obs_erro_ciclo != TIMEOUT + 1 || obs_n_erro != 1) begin errors++; $display("[TB] FAIL timeout_erro: got cycle %0d/%0d pulses expected cycle %0d", obs_erro_ciclo, obs_n_erro, TIMEOUT + 1); end
        checks++; if (obs_n_valida != 0) begin errors++; $display("[TB] FAIL timeout_valida: got %0d pulses expected 0", obs_n_valida); end
        checks++; if (obs_gap != TIMEOUT + 2 + PERIODO) begin errors++; $display("[TB] FAIL timeout_gap: got %0d expected %0d", obs_gap, TIMEOUT + 2 + PERIODO); end
        for (int n = 0; n < N_AMOSTRAS; n++) begin
            atraso = $urandom_range(1, TIMEOUT);
            executa_medida(1'b1, atraso, 50);
            esp     = modelo_amostra(50);
            gap_esp = atraso + 1 + PERIODO + ((esp >= 0) ? 1 : 0);
            checks++; if (obs_n_erro != 0 || obs_valida_ciclo != ((esp >= 0) ? atraso + 1 : 0)) begin errors++; $display("[TB] FAIL timeout_seq[%0d]: got erro %0d valida cycle %0d expected valida cycle %0d", n, obs_n_erro, obs_valida_ciclo, (esp >= 0) ? atraso + 1 : 0); end
            checks++; if (obs_gap != gap_esp) begin errors++; $display("[TB] FAIL timeout_seq_gap[%0d]: got %0d expected %0d", n, obs_gap, gap_esp); end
        end
        checks++; if (bus.media !== 12'd50) begin errors++; $display("[TB] FAIL timeout_media: got %0d expected 50", bus.media); end
    endtask

    // pronto arriving in the very cycle the timeout would fire must be accepted.
    task automatic test_pronto_no_limite();
        int valor, esp;
        valor = $urandom_range(0, 4095);
        executa_medida(1'b1, TIMEOUT, valor);
        esp = modelo_amostra(valor);
        checks++; if (obs_n_erro != 0) begin errors++; $display("[TB] FAIL limit_erro: got %0d pulses expected 0", obs_n_erro); end
        checks++; if (obs_gap != TIMEOUT + 1 + PERIODO + ((esp >= 0) ? 1 : 0)) begin errors++; $display("[TB] FAIL limit_gap: got %0d expected %0d", obs_gap, TIMEOUT + 1 + PERIODO + ((esp >= 0) ? 1 : 0)); end
    endtask

    // Dropping ligar discards partial work and ignores a late pronto.
    task automatic test_ligar_cai();
        int atraso, valor, esp;
        for (int n = 0; n < 2; n++) begin
            atraso = $urandom_range(1, TIMEOUT);
            valor  = $urandom_range(0, 4095);
            executa_medida(1'b1, atraso, valor);
            esp = modelo_amostra(valor);
            checks++; if (obs_gap != atraso + 1 + PERIODO + ((esp >= 0) ? 1 : 0)) begin errors++; $display("[TB] FAIL drop_pre_gap[%0d]: got %0d expected %0d", n, obs_gap, atraso + 1 + PERIODO + ((esp >= 0) ? 1 : 0)); end
        end
        bus.ligar = 1'b0;
        tick();
        checks++; if (bus.db_estado !== 4'd0 || bus.medir !== 1'b0) begin errors++; $display("[TB] FAIL drop_inicial: got estado %0d medir %b expected 0/0", bus.db_estado, bus.medir); end
        bus.pronto_medida = 1'b1;
        bus.medida_in     = 12'd4000;
        tick();
        bus.pronto_medida = 1'b0;
        checks++; if (bus.db_estado !== 4'd0 || bus.media_valida !== 1'b0 || bus.erro !== 1'b0) begin errors++; $display("[TB] FAIL drop_stray: got estado %0d valida %b erro %b expected 0", bus.db_estado, bus.media_valida, bus.erro); end
        checks++; if (bus.media !== 12'(ultima_media)) begin errors++; $display("[TB] FAIL drop_media_hold: got %0d expected %0d", bus.media, ultima_media); end
        amostras.delete();
        bus.ligar = 1'b1;
        tick();
        checks++; if (bus.medir !== 1'b1) begin errors++; $display("[TB] FAIL drop_restart: got medir %b expected 1", bus.medir); end
        for (int n = 0; n < N_AMOSTRAS; n++) begin
            atraso = $urandom_range(1, TIMEOUT);
            valor  = $urandom_range(0, 4095);
            executa_medida(1'b1, atraso, valor);
            esp = modelo_amostra(valor);
            checks++; if (obs_valida_ciclo != ((esp >= 0) ? atraso + 1 : 0)) begin errors++; $display("[TB] FAIL drop_valida[%0d]: got cycle %0d expected %0d", n, obs_valida_ciclo, (esp >= 0) ? atraso + 1 : 0); end
            if (esp >= 0) begin
                checks++; if (obs_media != esp) begin errors++; $display("[TB] FAIL drop_media[%0d]: got %0d expected %0d", n, obs_media, esp); end
            end
        end
    endtask

    // Random mix of answered and lost measurements.
    task automatic test_aleatorio();
        bit responde;
        int atraso, valor, esp, gap_esp;
        for (int n = 0; n < 16; n++) begin
            responde = ($urandom_range(0, 3) != 0);
            atraso   = $urandom_range(1, TIMEOUT);
            valor    = $urandom_range(0, 4095);
            executa_medida(responde, atraso, valor);
            if (responde) begin
                esp     = modelo_amostra(valor);
                gap_esp = atraso + 1 + PERIODO + ((esp >= 0) ? 1 : 0);
                checks++; if (obs_n_erro != 0 || obs_valida_ciclo != ((esp >= 0) ? atraso + 1 : 0) || obs_n_valida != ((esp >= 0) ? 1 : 0)) begin errors++; $display("[TB] FAIL rand_strobe[%0d]: got erro %0d valida cycle %0d expected valida cycle %0d", n, obs_n_erro, obs_valida_ciclo, (esp >= 0) ? atraso + 1 : 0); end
                if (esp >= 0) begin
                    checks++; if (obs_media != esp) begin errors++; $display("[TB] FAIL rand_media[%0d]: got %0d expected %0d", n, obs_media, esp); end
                end
            end else begin
                gap_esp = TIMEOUT + 2 + PERIODO;
                checks++; if (obs_erro_ciclo != TIMEOUT + 1 || obs_n_erro != 1 || obs_n_valida != 0) begin errors++; $display("[TB] FAIL rand_timeout[%0d]: got erro cycle %0d valida %0d expected %0d/0", n, obs_erro_ciclo, obs_n_valida, TIMEOUT + 1); end
            end
            checks++; if (obs_gap != gap_esp) begin errors++; $display("[TB] FAIL rand_gap[%0d]: got %0d expected %0d", n, obs_gap, gap_esp); end
        end
    endtask

    // Reset in the middle of AGUARDA must clear outputs without waiting for a clock edge.
    task automatic test_reset_assincrono();
        repeat (3) tick();
        checks++; if (bus.db_estado !== 4'd2) begin errors++; $display("[TB] FAIL async_pre_state: got %0d expected 2", bus.db_estado); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd0 || bus.medir !== 1'b0) begin errors++; $display("[TB] FAIL async_state: got estado %0d medir %b expected 0/0", bus.db_estado, bus.medir); end
        checks++; if (bus.media !== 12'd0 || bus.media_valida !== 1'b0 || bus.erro !== 1'b0) begin errors++; $display("[TB] FAIL async_outputs: got media %0d valida %b erro %b expected 0", bus.media, bus.media_valida, bus.erro); end
        bus.ligar = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("[TB] FAIL async_idle: got %0d expected 0", bus.db_estado); end
    endtask

    // Scenario sequence; each test starts where the previous one left the DUT.
    initial begin
        test_reset();
        test_media_basica(100, 1, 5, 101);
        test_media_basica(4095, 0, 5, 4095);
        test_timeout();
        test_pronto_no_limite();
        test_ligar_cai();
        test_aleatorio();
        test_reset_assincrono();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
